// File: rtl/regfile_2w2r_sb_if.sv
// Port bundle for the register file: read ports, two write ports, scoreboard set
// and busy outputs. master = pipeline (ID/WB), slave = register file.
interface regfile_2w2r_sb_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   // No valid/ready handshake: every input is sampled on each rising edge and
   // each *_en qualifies its own address/data; outputs are always valid.
   logic [ADDR_W-1:0] rd_addr_a;
   logic [DATA_W-1:0] rd_data_a;
   logic [ADDR_W-1:0] rd_addr_b;
   logic [DATA_W-1:0] rd_data_b;
   logic              busy_a;
   logic              busy_b;
   logic              wr0_en;
   logic [ADDR_W-1:0] wr0_addr;
   logic [DATA_W-1:0] wr0_data;
   logic              wr1_en;
   logic [ADDR_W-1:0] wr1_addr;
   logic [DATA_W-1:0] wr1_data;
   logic              sb_set_en;
   logic [ADDR_W-1:0] sb_set_addr;
   logic [ADDR_W:0]   busy_count;

   modport master (
      output rd_addr_a, rd_addr_b,
      output wr0_en, wr0_addr, wr0_data,
      output wr1_en, wr1_addr, wr1_data,
      output sb_set_en, sb_set_addr,
      input  rd_data_a, rd_data_b, busy_a, busy_b, busy_count
   );

   modport slave (
      input  rd_addr_a, rd_addr_b,
      input  wr0_en, wr0_addr, wr0_data,
      input  wr1_en, wr1_addr, wr1_data,
      input  sb_set_en, sb_set_addr,
      output rd_data_a, rd_data_b, busy_a, busy_b, busy_count
   );
endinterface

// File: rtl/regfile_2w2r_sb.sv
// 2-write/2-read register file with per-register busy scoreboard; r0 hardwired 0.
// Optional write-first forwarding on the read and busy ports: define RF_BYPASS_EN.
module regfile_2w2r_sb #(
   parameter int          DATA_W  = 32,
   parameter int          ADDR_W  = 5,
   parameter int          SP_IDX  = 29,
   parameter logic [31:0] SP_INIT = 32'h0000_0FFF
) (
   input logic               clk,
   input logic               reset,
   regfile_2w2r_sb_if.slave  rf
);
   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0]  busy_q, busy_d;
   logic [ADDR_W:0]   busy_count_q, busy_count_d;
   logic [DEPTH-1:0]  set_vec, clr_vec;

   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      for (int i = 1; i < DEPTH; i++) begin
         set_vec[i] = rf.sb_set_en && (rf.sb_set_addr == ADDR_W'(i));
         clr_vec[i] = (rf.wr0_en && (rf.wr0_addr == ADDR_W'(i))) ||
                      (rf.wr1_en && (rf.wr1_addr == ADDR_W'(i)));
      end
   end

   // wr1 is applied after wr0 so it wins a same-address collision.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) regs_d[i] = regs_q[i];
      for (int i = 1; i < DEPTH; i++) begin
         if (rf.wr0_en && (rf.wr0_addr == ADDR_W'(i))) regs_d[i] = rf.wr0_data;
         if (rf.wr1_en && (rf.wr1_addr == ADDR_W'(i))) regs_d[i] = rf.wr1_data;
      end
      regs_d[0] = '0;
   end

   // Set beats clear: a new producer issued in the same cycle as an older writeback.
   always_comb begin
      busy_d       = (busy_q & ~clr_vec) | set_vec;
      busy_d[0]    = 1'b0;
      busy_count_d = '0;
      for (int i = 0; i < DEPTH; i++)
         busy_count_d = busy_count_d + {{ADDR_W{1'b0}}, busy_d[i]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++)
            regs_q[i] <= (i == SP_IDX) ? DATA_W'(SP_INIT) : '0;
         busy_q       <= '0;
         busy_count_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
         busy_q       <= busy_d;
         busy_count_q <= busy_count_d;
      end
   end

`ifdef RF_BYPASS_EN
   always_comb begin
      rf.rd_data_a = regs_q[rf.rd_addr_a];
      if (rf.rd_addr_a != '0) begin
         if (rf.wr0_en && (rf.wr0_addr == rf.rd_addr_a)) rf.rd_data_a = rf.wr0_data;
         if (rf.wr1_en && (rf.wr1_addr == rf.rd_addr_a)) rf.rd_data_a = rf.wr1_data;
      end
      rf.rd_data_b = regs_q[rf.rd_addr_b];
      if (rf.rd_addr_b != '0) begin
         if (rf.wr0_en && (rf.wr0_addr == rf.rd_addr_b)) rf.rd_data_b = rf.wr0_data;
         if (rf.wr1_en && (rf.wr1_addr == rf.rd_addr_b)) rf.rd_data_b = rf.wr1_data;
      end
   end

   assign rf.busy_a = busy_q[rf.rd_addr_a] &&
                      !(clr_vec[rf.rd_addr_a] && !set_vec[rf.rd_addr_a]);
   assign rf.busy_b = busy_q[rf.rd_addr_b] &&
                      !(clr_vec[rf.rd_addr_b] && !set_vec[rf.rd_addr_b]);
`else
   // regs_q[0] and busy_q[0] are never written non-zero, so no address-0 guard.
   assign rf.rd_data_a = regs_q[rf.rd_addr_a];
   assign rf.rd_data_b = regs_q[rf.rd_addr_b];
   assign rf.busy_a    = busy_q[rf.rd_addr_a];
   assign rf.busy_b    = busy_q[rf.rd_addr_b];
`endif

   assign rf.busy_count = busy_count_q;
endmodule

// File: tb/tb_regfile_2w2r_sb.sv
// Scoreboard bench for regfile_2w2r_sb: directed scenarios plus random traffic,
// checked against an array/bit-vector model. Honours RF_BYPASS_EN.
module tb_regfile_2w2r_sb;
   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 32;

   typedef struct packed {
      logic [DW-1:0] da;
      logic [DW-1:0] db;
      logic          ba;
      logic          bb;
      logic [AW:0]   cnt;
   } exp_t;
   localparam int EXP_W = $bits(exp_t);

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   regfile_2w2r_sb_if #(.DATA_W(DW), .ADDR_W(AW)) rf_if ();

   regfile_2w2r_sb #(
      .DATA_W(DW), .ADDR_W(AW), .SP_IDX(29), .SP_INIT(32'h0000_0FFF)
   ) dut (
      .clk(clk), .reset(reset), .rf(rf_if)
   );

   logic [EXP_W-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;
   int txn    = 0;

   logic [DW-1:0]    m_regs [DEPTH];
   logic [DEPTH-1:0] m_busy;

   // ---------------- reference model ----------------
   function automatic void model_reset();
      for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
      m_regs[29] = 32'h0000_0FFF;
      m_busy     = '0;
   endfunction

   function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
      if (a == 0) return '0;
`ifdef RF_BYPASS_EN
      if (rf_if.wr1_en && rf_if.wr1_addr == a) return rf_if.wr1_data;
      if (rf_if.wr0_en && rf_if.wr0_addr == a) return rf_if.wr0_data;
`endif
      return m_regs[a];
   endfunction

   function automatic logic exp_busy(input logic [AW-1:0] a);
      if (a == 0) return 1'b0;
`ifdef RF_BYPASS_EN
      if (((rf_if.wr0_en && rf_if.wr0_addr == a) || (rf_if.wr1_en && rf_if.wr1_addr == a)) &&
          !(rf_if.sb_set_en && rf_if.sb_set_addr == a))
         return 1'b0;
`endif
      return m_busy[a];
   endfunction

   // Effect of one rising edge on the architectural state.
   function automatic void model_update();
      if (rf_if.wr0_en && rf_if.wr0_addr != 0) m_regs[rf_if.wr0_addr] = rf_if.wr0_data;
      if (rf_if.wr1_en && rf_if.wr1_addr != 0) m_regs[rf_if.wr1_addr] = rf_if.wr1_data;
      if (rf_if.wr0_en) m_busy[rf_if.wr0_addr] = 1'b0;
      if (rf_if.wr1_en) m_busy[rf_if.wr1_addr] = 1'b0;
      if (rf_if.sb_set_en) m_busy[rf_if.sb_set_addr] = 1'b1;
      m_busy[0] = 1'b0;
   endfunction

   // ---------------- driver ----------------
   task automatic set_idle();
      rf_if.wr0_en      = 1'b0; rf_if.wr0_addr = '0; rf_if.wr0_data = '0;
      rf_if.wr1_en      = 1'b0; rf_if.wr1_addr = '0; rf_if.wr1_data = '0;
      rf_if.sb_set_en   = 1'b0; rf_if.sb_set_addr = '0;
   endtask

   task automatic push_exp();
      exp_t e;
      e.da  = exp_rd(rf_if.rd_addr_a);
      e.db  = exp_rd(rf_if.rd_addr_b);
      e.ba  = exp_busy(rf_if.rd_addr_a);
      e.bb  = exp_busy(rf_if.rd_addr_b);
      e.cnt = (AW + 1)'($countones(m_busy));
      exp_q.push_back(e);
   endtask

   task automatic cycle();
      push_exp();
      @(posedge clk);
      model_update();
      #2;
   endtask

   task automatic check_now();
      push_exp();
      @(negedge clk);
      #1;
   endtask

   task automatic rd(input int a, input int b);
      rf_if.rd_addr_a = AW'(a);
      rf_if.rd_addr_b = AW'(b);
   endtask

   function automatic logic [AW-1:0] rnd_addr();
      if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 7));
      return AW'($urandom_range(0, DEPTH - 1));
   endfunction

   // ---------------- monitor / scoreboard ----------------
   task automatic check_val(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s txn %0d: got %h expected %h", name, txn, act, exp);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_t'(exp_q.pop_front());
            check_val("rd_data_a", rf_if.rd_data_a, e.da);
            check_val("rd_data_b", rf_if.rd_data_b, e.db);
            check_val("busy_a", {31'b0, rf_if.busy_a}, {31'b0, e.ba});
            check_val("busy_b", {31'b0, rf_if.busy_b}, {31'b0, e.bb});
            check_val("busy_count", {26'b0, rf_if.busy_count}, {26'b0, e.cnt});
            txn++;
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b1;
      set_idle();
      rd(29, 0);
      model_reset();
      #2;
      check_now();
      @(posedge clk);
      #2;
      reset = 1'b0;

      // Reset contents of every register.
      for (int i = 0; i < DEPTH; i += 2) begin
         rd(i, i + 1);
         cycle();
      end

      // wr0/wr1 collision on r5: wr1 data stored.
      set_idle();
      rf_if.wr0_en = 1'b1; rf_if.wr0_addr = 5; rf_if.wr0_data = 32'h1234_5678;
      rf_if.wr1_en = 1'b1; rf_if.wr1_addr = 5; rf_if.wr1_data = 32'hCAFE_F00D;
      rd(5, 4);
      cycle();
      set_idle();
      cycle();

      // r0 write and sb_set are ignored.
      rf_if.wr0_en = 1'b1; rf_if.wr0_addr = 0; rf_if.wr0_data = 32'hFFFF_FFFF;
      rd(0, 0);
      cycle();
      set_idle();
      rf_if.sb_set_en = 1'b1; rf_if.sb_set_addr = 0;
      cycle();
      set_idle();
      cycle();

      // Set wins over same-cycle clear on r3.
      rf_if.sb_set_en = 1'b1; rf_if.sb_set_addr = 3;
      rd(3, 0);
      cycle();
      rf_if.wr0_en = 1'b1; rf_if.wr0_addr = 3; rf_if.wr0_data = 32'd7;
      cycle();
      set_idle();
      cycle();
      // Clear of a non-busy register leaves the count alone.
      rf_if.wr1_en = 1'b1; rf_if.wr1_addr = 12; rf_if.wr1_data = 32'h55;
      cycle();
      rf_if.wr1_addr = 3; rf_if.wr1_data = 32'h9;
      cycle();
      set_idle();
      cycle();

      // Same-cycle write to r8 with a read of r8.
      rf_if.wr0_en = 1'b1; rf_if.wr0_addr = 8; rf_if.wr0_data = 32'h0000_1111;
      rd(1, 8);
      cycle();
      set_idle();
      rf_if.wr1_en = 1'b1; rf_if.wr1_addr = 8; rf_if.wr1_data = 32'hA5A5_A5A5;
      rd(8, 8);
      cycle();
      set_idle();
      cycle();

      // Random traffic.
      for (int n = 0; n < 400; n++) begin
         rf_if.rd_addr_a   = rnd_addr();
         rf_if.rd_addr_b   = rnd_addr();
         rf_if.wr0_en      = 1'($urandom_range(0, 1));
         rf_if.wr0_addr    = rnd_addr();
         rf_if.wr0_data    = $urandom;
         rf_if.wr1_en      = 1'($urandom_range(0, 1));
         rf_if.wr1_addr    = rnd_addr();
         rf_if.wr1_data    = $urandom;
         rf_if.sb_set_en   = 1'($urandom_range(0, 1));
         rf_if.sb_set_addr = rnd_addr();
         cycle();
      end

      // Fill the scoreboard, then async reset between edges.
      set_idle();
      for (int i = 1; i < DEPTH; i++) begin
         rf_if.sb_set_en = 1'b1; rf_if.sb_set_addr = AW'(i);
         rd(i, i - 1);
         cycle();
      end
      set_idle();
      rd(29, 31);
      cycle();
      reset = 1'b1;
      model_reset();
      #1;
      check_now();
      @(posedge clk);
      #2;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rd(29, i + 1);
         cycle();
      end

      repeat (3) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
